// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit and receive paths.
package uart_pkg;
    typedef logic [15:0] timer_t;
    typedef logic [7:0] data_t;
    localparam int DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
endpackage

// File: rtl/uart_rx_counter.sv
// counter: tick counter with terminal count n; ovf marks the last count before wrap.
module counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [W-1:0] n,
    output logic         ovf
);
    logic [W-1:0] cnt;

    assign ovf = cnt == n - W'(1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (!enable || ovf) cnt <= '0;
        else cnt <= cnt + W'(1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with mid-bit sampling, optional parity and frame/parity error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   rx,
    input  timer_t bit_time,
    output data_t  rx_data,
    output logic   rx_valid,
    output logic   frame_err,
    output logic   parity_err,
    output logic   busy
);
    rx_state_e  state, state_nx;
    logic       sync1, rx_s, rx_s_d, ovf, par_bad;
    logic [2:0] idx;
    data_t      shreg;
    timer_t     half;

    assign half = bit_time >> 1;
    assign busy = state != IDLE;

    // half a bit period in START lands every later sample at mid-bit
    counter #(.W($bits(timer_t))) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (busy),
        .n      (state == START ? half : bit_time),
        .ovf    (ovf)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!rx_s && rx_s_d) state_nx = START;
            START:   if (ovf) state_nx = rx_s ? IDLE : DATA;
            DATA:    if (ovf && idx == 3'(DATA_BITS - 1)) state_nx = PARITY_EN ? PARITY : STOP;
            PARITY:  if (ovf) state_nx = STOP;
            STOP:    if (ovf) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            {sync1, rx_s, rx_s_d} <= '1;
            idx        <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            {sync1, rx_s, rx_s_d} <= {rx, sync1, rx_s};
            rx_valid <= 1'b0;
            if (state == IDLE) idx <= '0;
            if (state == DATA && ovf) begin
                shreg[idx] <= rx_s;
                idx        <= idx + 3'd1;
            end
            if (state == PARITY && ovf) par_bad <= (^shreg ^ rx_s) != PARITY_ODD;
            if (state == STOP && ovf) begin
                rx_data    <= shreg;
                frame_err  <= !rx_s;
                parity_err <= PARITY_EN && par_bad;
                rx_valid   <= 1'b1;
            end
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench driving an 8N1 and an 8E1 uart_rx with directed and random frames.
module tb_uart_rx;
    import uart_pkg::*;

    logic   clk = 1'b0, rst = 1'b0, rx_a = 1'b1, rx_b = 1'b1;
    timer_t bit_time = 16'd16;
    data_t  data_a, data_b;
    logic   va, vb, fe_a, fe_b, pe_a, pe_b, busy_a, busy_b;
    logic   va_d = 1'b0, vb_d = 1'b0;
    int     checks = 0, failures = 0, cyc = 0;

    typedef struct {
        data_t d;
        bit    fe;
        bit    pe;
        int    c;
    } exp_t;
    exp_t qa[$], qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .bit_time(bit_time), .rx_data(data_a),
        .rx_valid(va), .frame_err(fe_a), .parity_err(pe_a), .busy(busy_a)
    );

    uart_rx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .bit_time(bit_time), .rx_data(data_b),
        .rx_valid(vb), .frame_err(fe_b), .parity_err(pe_b), .busy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input data_t d, input logic fe,
                       input logic pe, input logic bz, input logic vd);
        chk({tag, "_data"}, int'(d), int'(e.d));
        chk({tag, "_frame_err"}, int'(fe), int'(e.fe));
        chk({tag, "_parity_err"}, int'(pe), int'(e.pe));
        chk({tag, "_valid_cycle"}, cyc, e.c);
        chk({tag, "_busy_on_valid"}, int'(bz), 0);
        chk({tag, "_pulse_width"}, int'(vd), 0);
    endtask

    task automatic spurious(input string tag);
        checks++;
        failures++;
        $display("FAIL %s_spurious_valid: rx_valid=1 with no frame expected", tag);
    endtask

    // Monitor: every rx_valid is matched against the oldest expected frame
    always @(negedge clk) begin
        if (rst && va) begin
            if (qa.size() == 0) spurious("a");
            else cmp("a", qa.pop_front(), data_a, fe_a, pe_a, busy_a, va_d);
        end
        if (rst && vb) begin
            if (qb.size() == 0) spurious("b");
            else cmp("b", qb.pop_front(), data_b, fe_b, pe_b, busy_b, vb_d);
        end
        va_d = va;
        vb_d = vb;
    end

    task automatic hold(input bit b, input logic v, input int n);
        if (b) rx_b = v;
        else rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    // Reference: 3-clock synchroniser/detect delay, half a bit to the start sample, then whole bits
    task automatic send(input bit b, input data_t d, input bit pbit, input bit stop);
        int   bt;
        exp_t e;
        bt   = int'(bit_time);
        e.d  = d;
        e.fe = !stop;
        e.pe = b && ((($countones(d) + int'(pbit)) % 2) != 0);
        e.c  = cyc + 3 + bt / 2 + (b ? 10 : 9) * bt;
        if (b) qb.push_back(e);
        else qa.push_back(e);
        hold(b, 1'b0, bt);
        for (int i = 0; i < 8; i++) hold(b, d[i], bt);
        if (b) hold(b, pbit, bt);
        hold(b, stop, bt);
    endtask

    task automatic drain();
        for (int n = 0; n < 1000 && (qa.size() + qb.size()) != 0; n++) @(negedge clk);
        chk("drain_pending", qa.size() + qb.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_data_a"}, int'(data_a), 0);
        chk({tag, "_flags_a"}, int'({va, fe_a, pe_a, busy_a}), 0);
        chk({tag, "_data_b"}, int'(data_b), 0);
        chk({tag, "_flags_b"}, int'({vb, fe_b, pe_b, busy_b}), 0);
    endtask

    initial begin
        bit    b;
        data_t d;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;
        @(negedge clk);

        send(1'b0, 8'hA5, 1'b0, 1'b1);
        drain();

        hold(1'b0, 1'b0, 5);
        hold(1'b0, 1'b1, 40);
        chk("false_start_busy", int'(busy_a), 0);
        chk("false_start_data", int'(data_a), 'hA5);

        send(1'b1, 8'h07, 1'b1, 1'b1);
        send(1'b1, 8'h07, 1'b0, 1'b1);
        drain();

        bit_time = 16'd8;
        send(1'b0, 8'h00, 1'b0, 1'b1);
        send(1'b0, 8'hFF, 1'b0, 1'b1);
        drain();

        bit_time = 16'd16;
        send(1'b0, 8'h3C, 1'b0, 1'b0);
        drain();
        hold(1'b0, 1'b0, 48);
        chk("ferr_low_line_busy", int'(busy_a), 0);
        chk("ferr_hold", int'(fe_a), 1);
        hold(1'b0, 1'b1, 16);

        d = 8'h5A;
        hold(1'b0, 1'b0, 16);
        for (int i = 0; i < 3; i++) hold(1'b0, d[i], 16);
        hold(1'b0, d[3], 8);
        chk("pre_reset_busy", int'(busy_a), 1);
        #2 rst = 1'b0;
        #1 chk_reset("mid_frame_reset");
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(1'b0, 8'h5A, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 40; i++) begin
            b = 1'($urandom_range(0, 1));
            bit_time = timer_t'($urandom_range(4, 20));
            hold(b, 1'b1, int'(bit_time) + int'($urandom_range(0, 3)));
            send(b, data_t'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            drain();
        end

        hold(1'b0, 1'b1, 10);
        chk("end_queue_a", qa.size(), 0);
        chk("end_queue_b", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: time limit reached before the bench completed");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
